// File: rtl/move_sequencer_if.sv
// Bundle of signals between the move sequencer, the roll button logic and
// the player controller.
// Optional macro MOVE_TIMEOUT_EN adds the move_err ack-timeout pulse.
interface move_sequencer_if;
    logic       roll_req;
    logic       is_moving;
    logic [3:0] current_tile;
    logic       move_trigger;
    logic [2:0] dice_value;
    logic       busy;
    logic       turn_done;
    logic       at_goal;
`ifdef MOVE_TIMEOUT_EN
    logic       move_err;
`endif

    // Sequencer side: consumes button/player status, drives step commands.
    modport master (
`ifdef MOVE_TIMEOUT_EN
        output move_err,
`endif
        input  roll_req,
        input  is_moving,
        input  current_tile,
        output move_trigger,
        output dice_value,
        output busy,
        output turn_done,
        output at_goal
    );

    // Environment side: button logic and player controller.
    modport slave (
`ifdef MOVE_TIMEOUT_EN
        input  move_err,
`endif
        output roll_req,
        output is_moving,
        output current_tile,
        input  move_trigger,
        input  dice_value,
        input  busy,
        input  turn_done,
        input  at_goal
    );
endinterface

// File: rtl/move_sequencer.sv
// move_sequencer: turn initiator for the board-game UI.
// A roll-button rising edge draws a die value 1..6 from a free-running LFSR,
// then issues one move_trigger pulse per step, waiting for the player
// controller's is_moving to rise and fall before each next step. Steps are
// clipped so the player never passes MAX_TILE.
// Optional macro MOVE_TIMEOUT_EN: abandon the turn (move_err pulse) when
// is_moving does not rise within ACK_TIMEOUT cycles of a trigger.
module move_sequencer #(
    parameter int         MAX_TILE    = 9,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         ACK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    move_sequencer_if.master bus
);

    localparam logic [7:0] GOAL = 8'(MAX_TILE);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ROLL      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] lfsr_r;
    logic       roll_prev_r;
    logic       goal_r;
    logic       trig_r, trig_s;
    logic [2:0] dice_r, dice_s;
    logic [2:0] steps_r, steps_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;

    logic       roll_edge_s;
    logic [7:0] tile_s;
    logic [2:0] die_s;
    logic [7:0] room_s;
    logic [2:0] clip_s;

`ifdef MOVE_TIMEOUT_EN
    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
    logic [7:0] cnt_r, cnt_s;
    logic       err_r, err_s;
`endif

    // 8-bit Fibonacci LFSR step, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Die draw, roll edge and the step count clipped to the tiles left.
    always_comb begin
        tile_s      = {4'd0, bus.current_tile};
        roll_edge_s = bus.roll_req & ~roll_prev_r;
        die_s       = 3'((lfsr_r % 8'd6) + 8'd1);
        if (tile_s < GOAL) begin
            room_s = GOAL - tile_s;
        end else begin
            room_s = 8'd0;
        end
        // Never load zero steps: a zero would underflow in WAIT_DONE.
        if (room_s == 8'd0) begin
            clip_s = 3'd1;
        end else if ({5'd0, die_s} < room_s) begin
            clip_s = die_s;
        end else begin
            clip_s = 3'(room_s);
        end
    end

    // Free-running LFSR, button edge history and goal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r      <= LFSR_SEED;
            roll_prev_r <= 1'b0;
            goal_r      <= 1'b0;
        end else begin
            lfsr_r      <= lfsr_next(lfsr_r);
            roll_prev_r <= bus.roll_req;
            goal_r      <= (tile_s >= GOAL);
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            trig_r  <= 1'b0;
            dice_r  <= 3'd0;
            steps_r <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            cnt_r   <= 8'd0;
            err_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            trig_r  <= trig_s;
            dice_r  <= dice_s;
            steps_r <= steps_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
`ifdef MOVE_TIMEOUT_EN
            cnt_r   <= cnt_s;
            err_r   <= err_s;
`endif
        end
    end

    // Next-state and next-output decode for the turn sequence.
    always_comb begin
        state_s = state_r;
        trig_s  = 1'b0;
        dice_s  = dice_r;
        steps_s = steps_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
`ifdef MOVE_TIMEOUT_EN
        cnt_s   = cnt_r;
        err_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                // Edges at the goal or while busy are dropped, not queued.
                if (roll_edge_s && (tile_s < GOAL)) begin
                    state_s = ST_ROLL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ROLL: begin
                dice_s  = die_s;
                steps_s = clip_s;
                busy_s  = 1'b1;
                state_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                trig_s  = 1'b1;
`ifdef MOVE_TIMEOUT_EN
                cnt_s   = 8'd0;
`endif
                state_s = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // A step only counts once is_moving has been seen high here,
                // so a controller still busy from before cannot fake a step.
                if (bus.is_moving) begin
                    state_s = ST_WAIT_DONE;
                end else begin
`ifdef MOVE_TIMEOUT_EN
                    if (cnt_r == ACK_LAST) begin
                        err_s   = 1'b1;
                        steps_s = 3'd0;
                        state_s = ST_FINISH;
                    end else begin
                        cnt_s   = cnt_r + 8'd1;
                        state_s = ST_WAIT_ACK;
                    end
`else
                    state_s = ST_WAIT_ACK;
`endif
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.is_moving) begin
                    steps_s = steps_r - 3'd1;
                    if (steps_r == 3'd1) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_FINISH: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.move_trigger = trig_r;
    assign bus.dice_value   = dice_r;
    assign bus.busy         = busy_r;
    assign bus.turn_done    = done_r;
    assign bus.at_goal      = goal_r;
`ifdef MOVE_TIMEOUT_EN
    assign bus.move_err     = err_r;
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: behavioural player controller,
// LFSR reference for die prediction, expected-turn scoreboard queue.
module tb_move_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    move_sequencer_if bus();

    move_sequencer #(
        .MAX_TILE    (9),
        .LFSR_SEED   (8'hA5),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference LFSR ----------------
    logic [7:0] m_lfsr;

    function automatic logic [7:0] ref_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int die_of(input logic [7:0] v);
        return int'(v % 8'd6) + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= ref_next(m_lfsr);
    end

    // ---------------- player controller model ----------------
    logic       model_en  = 1'b1;
    logic       load_tile = 1'b1;
    logic [3:0] load_val  = 4'd0;
    int         mv_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.is_moving <= 1'b0;
            mv_cnt        <= 0;
            if (load_tile) bus.current_tile <= load_val;
        end else if (load_tile) begin
            bus.current_tile <= load_val;
        end else if (mv_cnt > 0) begin
            if (mv_cnt == 1) begin
                bus.is_moving    <= 1'b0;
                bus.current_tile <= bus.current_tile + 4'd1;
            end
            mv_cnt <= mv_cnt - 1;
        end else if (model_en && bus.move_trigger) begin
            bus.is_moving <= 1'b1;
            mv_cnt        <= 40;
        end
    end

    // ---------------- output monitor ----------------
    int cyc, pulse_cnt, done_cnt, wide_cnt, busy_cyc, trig_cyc;
    bit trig_prev;
`ifdef MOVE_TIMEOUT_EN
    int err_cnt, err_cyc, err_wide;
    bit err_prev;
`endif

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.move_trigger) begin
            pulse_cnt <= pulse_cnt + 1;
            trig_cyc  <= cyc;
        end
        if (bus.move_trigger && trig_prev) wide_cnt <= wide_cnt + 1;
        trig_prev <= bus.move_trigger;
        if (bus.turn_done) done_cnt <= done_cnt + 1;
        if (bus.busy)      busy_cyc <= busy_cyc + 1;
`ifdef MOVE_TIMEOUT_EN
        if (bus.move_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (bus.move_err && err_prev) err_wide <= err_wide + 1;
        err_prev <= bus.move_err;
`endif
    end

    // ---------------- scoreboard and checks ----------------
    typedef struct {
        int dice;
        int pulses;
        int tile;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int tile;
        int idle;
        int goal;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_tile(input int v);
        @(negedge clk);
        load_val  = 4'(v);
        load_tile = 1'b1;
        @(negedge clk);
        load_tile = 1'b0;
    endtask

    // Wait for a negedge where the predicted die lies in [lo,hi], then raise
    // roll_req for 'hold' cycles. The die is drawn from the LFSR value one
    // cycle after the edge is sampled.
    task automatic start_roll(input int lo, input int hi, input int hold, output int pred);
        pred = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            pred = die_of(ref_next(m_lfsr));
            if (pred >= lo && pred <= hi) break;
        end
        bus.roll_req = 1'b1;
        repeat (hold) @(negedge clk);
        bus.roll_req = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        for (int i = 0; i < 1500 && done_cnt <= d0; i++) @(negedge clk);
        check({tag, "_done_seen"}, int'(done_cnt > d0), 1);
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic push_turn(input int pred, input int tile);
        exp_t e;
        e.dice   = pred;
        e.pulses = min_i(pred, 9 - tile);
        e.tile   = tile + e.pulses;
        sb.push_back(e);
    endtask

    task automatic do_turn(input int tile, input string tag);
        exp_t e;
        int p0, d0, w0, b0, pred;
        set_tile(tile);
        p0 = pulse_cnt; d0 = done_cnt; w0 = wide_cnt; b0 = busy_cyc;
        start_roll(1, 6, 1, pred);
        push_turn(pred, tile);
        wait_done(d0, tag);
        cycles(2);
        e = sb.pop_front();
        check({tag, "_dice"},   int'(bus.dice_value), e.dice);
        check({tag, "_pulses"}, pulse_cnt - p0, e.pulses);
        check({tag, "_tile"},   int'(bus.current_tile), e.tile);
        check({tag, "_width"},  wide_cnt - w0, 0);
        check({tag, "_dones"},  done_cnt - d0, 1);
        check({tag, "_busy_seen"}, int'(busy_cyc > b0), 1);
        check({tag, "_busy_end"},  int'(bus.busy), 0);
    endtask

    initial begin
        vec_t tbl[4];
        exp_t e;
        int p0, d0, b0, pred, ok;

        tbl[0] = '{tile: 0, idle: 3,  goal: 0};
        tbl[1] = '{tile: 2, idle: 7,  goal: 0};
        tbl[2] = '{tile: 8, idle: 1,  goal: 1};
        tbl[3] = '{tile: 1, idle: 11, goal: 0};

        bus.roll_req = 1'b0;
        cycles(3);
        // reset state
        check("rst_trigger", int'(bus.move_trigger), 0);
        check("rst_busy",    int'(bus.busy), 0);
        check("rst_done",    int'(bus.turn_done), 0);
        check("rst_goal",    int'(bus.at_goal), 0);
        check("rst_dice",    int'(bus.dice_value), 0);
        load_tile = 1'b0;
        rst_n = 1'b1;
        cycles(2);

        // Test 1: first turn from tile 0
        do_turn(0, "t1");
        check("t1_dice_range", int'(bus.dice_value >= 3'd1 && bus.dice_value <= 3'd6), 1);

        // Table-driven turns
        for (int i = 0; i < 4; i++) begin
            cycles(tbl[i].idle);
            do_turn(tbl[i].tile, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_goal", i), int'(bus.at_goal), tbl[i].goal);
        end

        // Test 2: tile 7 with a die of 5 clips to 2 steps, then goal blocks rolls
        set_tile(7);
        p0 = pulse_cnt; d0 = done_cnt;
        start_roll(5, 5, 1, pred);
        push_turn(pred, 7);
        wait_done(d0, "t2");
        cycles(2);
        e = sb.pop_front();
        check("t2_dice",   int'(bus.dice_value), 5);
        check("t2_pulses", pulse_cnt - p0, 2);
        check("t2_tile",   int'(bus.current_tile), 9);
        check("t2_goal",   int'(bus.at_goal), 1);
        p0 = pulse_cnt; d0 = done_cnt; b0 = busy_cyc;
        start_roll(1, 6, 1, pred);
        cycles(30);
        check("t2_goal_pulses", pulse_cnt - p0, 0);
        check("t2_goal_busy",   busy_cyc - b0, 0);
        check("t2_goal_dones",  done_cnt - d0, 0);
        check("t2_goal_dice",   int'(bus.dice_value), 5);

        // Test 3: roll edges while busy are ignored and not queued
        set_tile(0);
        p0 = pulse_cnt; d0 = done_cnt;
        start_roll(1, 6, 1, pred);
        push_turn(pred, 0);
        cycles(10);
        for (int k = 0; k < 3; k++) begin
            bus.roll_req = 1'b1;
            cycles(2);
            bus.roll_req = 1'b0;
            cycles(2);
        end
        wait_done(d0, "t3");
        e = sb.pop_front();
        cycles(300);
        check("t3_pulses", pulse_cnt - p0, e.pulses);
        check("t3_dones",  done_cnt - d0, 1);
        check("t3_busy",   int'(bus.busy), 0);

        // Test 4: roll_req held high for 200 cycles gives one turn
        set_tile(0);
        p0 = pulse_cnt; d0 = done_cnt;
        start_roll(1, 6, 200, pred);
        push_turn(pred, 0);
        wait_done(d0, "t4");
        e = sb.pop_front();
        cycles(300);
        check("t4_pulses", pulse_cnt - p0, e.pulses);
        check("t4_dones",  done_cnt - d0, 1);
        check("t4_dice",   int'(bus.dice_value), e.dice);

        // Test 5: reset during WAIT_DONE of step 2
        set_tile(0);
        p0 = pulse_cnt;
        start_roll(2, 6, 1, pred);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ((pulse_cnt - p0) >= 2 && bus.is_moving) begin
                ok = 1;
                break;
            end
        end
        check("t5_reached_step2", ok, 1);
        check("t5_busy_before", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_trigger", int'(bus.move_trigger), 0);
        check("t5_rst_busy",    int'(bus.busy), 0);
        check("t5_rst_done",    int'(bus.turn_done), 0);
        check("t5_rst_goal",    int'(bus.at_goal), 0);
        check("t5_rst_dice",    int'(bus.dice_value), 0);
        cycles(2);
        rst_n = 1'b1;
        p0 = pulse_cnt; b0 = busy_cyc;
        cycles(100);
        check("t5_idle_pulses", pulse_cnt - p0, 0);
        check("t5_idle_busy",   busy_cyc - b0, 0);
        check("t5_idle_dice",   int'(bus.dice_value), 0);
        do_turn(1, "t5_after");

`ifdef MOVE_TIMEOUT_EN
        // Test 6: player never acknowledges
        model_en = 1'b0;
        set_tile(0);
        p0 = pulse_cnt; d0 = done_cnt; b0 = err_cnt;
        start_roll(1, 6, 1, pred);
        for (int i = 0; i < 400 && err_cnt == b0; i++) @(negedge clk);
        check("t6_err_seen", err_cnt - b0, 1);
        check("t6_err_delay", err_cyc - trig_cyc, 64);
        wait_done(d0, "t6");
        cycles(3);
        check("t6_pulses",   pulse_cnt - p0, 1);
        check("t6_dones",    done_cnt - d0, 1);
        check("t6_err_wide", err_wide, 0);
        check("t6_busy",     int'(bus.busy), 0);
        model_en = 1'b1;
`endif

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
